// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator. One shared period counter feeds CHANNELS
// independent duty comparators. Supports edge-aligned and center-aligned
// counting. Period, duty and mode are double-buffered: writes land in a
// pending register set and are copied to the active set only at a period
// boundary, so every output period is complete and glitch-free.
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   rst           synchronous, active-high reset
//   en            1 = counter runs; 0 = counter, direction and outputs hold
//   period_in     new period value (pending until the next boundary)
//   period_we     write strobe for period_in
//   duty_in       new duty value
//   duty_ch       channel addressed by duty_we (values >= CHANNELS ignored)
//   duty_we       write strobe for duty_in into pending duty[duty_ch]
//   mode_in       0 = edge-aligned, 1 = center-aligned
//   mode_we       write strobe for mode_in
//   pwm_out       registered PWM outputs, one per channel
//   cnt           current counter value
//   period_start  one-cycle pulse in the first cycle of each period
//   upd_pending   high while a pending write has not yet been loaded
//
// Write strobes are single-cycle requests with no back-pressure: a write is
// accepted on any rising edge where its strobe is high and rst is low.
// -----------------------------------------------------------------------------
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    period_in,
    input  logic                period_we,
    input  logic [WIDTH-1:0]    duty_in,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic                duty_we,
    input  logic                mode_in,
    input  logic                mode_we,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [WIDTH-1:0]    cnt,
    output logic                period_start,
    output logic                upd_pending
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    // Counting direction, only meaningful in center-aligned mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t             dir;

    // Active configuration (used by counter and comparators).
    logic [WIDTH-1:0] act_period;
    logic             act_mode;
    logic [WIDTH-1:0] act_duty  [CHANNELS];

    // Pending configuration (written by the strobes).
    logic [WIDTH-1:0] pend_period;
    logic             pend_mode;
    logic [WIDTH-1:0] pend_duty [CHANNELS];

    logic [WIDTH-1:0] top_cnt;      // effective period minus one
    logic             at_boundary;  // counter is in the last cycle of a period
    logic             boundary;     // boundary edge actually taken (needs en)
    logic             duty_ok;
    logic             wr_any;

    // A period of 0 behaves like a period of 1, so the top count is 0 for both.
    always_comb begin
        top_cnt = '0;
        if (act_period != '0) begin
            top_cnt = act_period - ONE;
        end
    end

    // Edge mode ends a period on the top count; center mode ends it when the
    // down-count reaches 0.
    always_comb begin
        at_boundary = 1'b0;
        if (act_mode) begin
            at_boundary = (dir == DIR_DOWN) && (cnt == '0);
        end else begin
            at_boundary = (cnt == top_cnt);
        end
    end

    assign boundary = en && at_boundary;
    assign duty_ok  = ({1'b0, duty_ch} < CH_LIMIT);
    assign wr_any   = period_we || mode_we || (duty_we && duty_ok);

    // -------------------------------------------------------------------------
    // Counter and direction
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (boundary) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (en) begin
            if (!act_mode) begin
                // Not at the boundary, so cnt < top_cnt: no wrap possible.
                cnt <= cnt + ONE;
            end else begin
                case (dir)
                    DIR_UP: begin
                        // Turnaround: hold the top count for a second cycle.
                        if (cnt == top_cnt) begin
                            dir <= DIR_DOWN;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    DIR_DOWN: begin
                        // cnt == 0 while down is the boundary, handled above.
                        cnt <= cnt - ONE;
                    end
                    default: begin
                        dir <= DIR_UP;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending and active configuration registers
    // -------------------------------------------------------------------------
    // On a boundary the active set takes the pending values as they were
    // before this edge; a write on the same edge therefore waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_period  <= '1;
            pend_period <= '1;
            act_mode    <= 1'b0;
            pend_mode   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_duty[i]  <= '0;
                pend_duty[i] <= '0;
            end
        end else begin
            if (boundary) begin
                act_period <= pend_period;
                act_mode   <= pend_mode;
                for (int i = 0; i < CHANNELS; i++) begin
                    act_duty[i] <= pend_duty[i];
                end
            end
            if (period_we) begin
                pend_period <= period_in;
            end
            if (mode_we) begin
                pend_mode <= mode_in;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_we && (duty_ch == CH_W'(i))) begin
                    pend_duty[i] <= duty_in;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start <= 1'b0;
            upd_pending  <= 1'b0;
        end else begin
            period_start <= boundary;
            if (boundary) begin
                // Everything pending has just been loaded, except a write
                // arriving on this very edge.
                upd_pending <= wr_any;
            end else if (wr_any) begin
                upd_pending <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Comparators: output lags the counter by one cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else if (en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (cnt < act_duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//
// Self-checking bench for pwm_multi. A behavioural model tracks the position
// within the current period as a phase index and derives the counter value
// and outputs from it with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [WIDTH-1:0]    period_in;
    logic                period_we;
    logic [WIDTH-1:0]    duty_in;
    logic [CH_W-1:0]     duty_ch;
    logic                duty_we;
    logic                mode_in;
    logic                mode_we;
    logic [CHANNELS-1:0] pwm_out;
    logic [WIDTH-1:0]    cnt;
    logic                period_start;
    logic                upd_pending;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------------ clock
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    pwm_multi #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period_in    (period_in),
        .period_we    (period_we),
        .duty_in      (duty_in),
        .duty_ch      (duty_ch),
        .duty_we      (duty_we),
        .mode_in      (mode_in),
        .mode_we      (mode_we),
        .pwm_out      (pwm_out),
        .cnt          (cnt),
        .period_start (period_start),
        .upd_pending  (upd_pending)
    );

    // ------------------------------------------------------- reference model
    int                  m_act_p, m_pend_p;
    bit                  m_act_m, m_pend_m;
    int                  m_act_d  [CHANNELS];
    int                  m_pend_d [CHANNELS];
    int                  m_phase;   // cycle index inside the current period
    logic [CHANNELS-1:0] m_pwm;
    bit                  m_ps, m_upd;

    function automatic int m_pe();
        return (m_act_p == 0) ? 1 : m_act_p;
    endfunction

    function automatic int m_len();
        return m_act_m ? 2 * m_pe() : m_pe();
    endfunction

    // Edge: counter equals the phase. Center: up for Pe cycles, then mirrored.
    function automatic int m_cnt();
        int pe;
        pe = m_pe();
        if (!m_act_m || m_phase < pe) return m_phase;
        return 2 * pe - 1 - m_phase;
    endfunction

    task automatic model_reset();
        m_act_p  = (1 << WIDTH) - 1;
        m_pend_p = (1 << WIDTH) - 1;
        m_act_m  = 1'b0;
        m_pend_m = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_act_d[i]  = 0;
            m_pend_d[i] = 0;
        end
        m_phase = 0;
        m_pwm   = '0;
        m_ps    = 1'b0;
        m_upd   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        bit wr;
        int c;
        if (rst) begin
            model_reset();
            return;
        end
        wr = period_we || mode_we || duty_we;
        if (en) begin
            c = m_cnt();
            for (int i = 0; i < CHANNELS; i++) m_pwm[i] = (c < m_act_d[i]);
            if (m_phase == m_len() - 1) begin
                m_phase = 0;
                m_act_p = m_pend_p;
                m_act_m = m_pend_m;
                for (int i = 0; i < CHANNELS; i++) m_act_d[i] = m_pend_d[i];
                m_ps  = 1'b1;
                m_upd = wr;
            end else begin
                m_phase++;
                m_ps  = 1'b0;
                m_upd = m_upd || wr;
            end
        end else begin
            m_ps  = 1'b0;
            m_upd = m_upd || wr;
        end
        if (period_we) m_pend_p = int'(period_in);
        if (mode_we)   m_pend_m = mode_in;
        if (duty_we)   m_pend_d[duty_ch] = int'(duty_in);
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic idle();
        period_we = 1'b0;
        duty_we   = 1'b0;
        mode_we   = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            period_we = 1'b1; period_in = WIDTH'($urandom_range(1, 200));
            duty_we   = 1'b1; duty_ch   = CH_W'($urandom_range(0, 3));
            duty_in   = WIDTH'($urandom_range(1, 255));
            mode_we   = 1'b1; mode_in   = 1'b1;
            tick();
            n_vec++;
            if ({pwm_out, cnt, period_start, upd_pending} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got pwm=%b cnt=%0d ps=%b upd=%b, want all 0",
                         pwm_out, cnt, period_start, upd_pending);
            end
        end
        rst = 1'b0;
        idle();
        // Run across the first boundary: if a strobe had reached the pending
        // registers, mode/duties would change after the load.
        for (int k = 0; k < 262; k++) begin
            tick();
            n_vec++;
            if ({pwm_out, cnt, period_start, upd_pending} !==
                {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                n_err++;
                $display("FAIL reset_pending: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                         pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
            end
        end
    endtask

    task automatic test_edge();
        int duties [4] = '{0, 3, 10, 12};
        int want   [4] = '{0, 3, 10, 10};
        int hi     [4];
        int ps_n, guard;
        for (int ch = 0; ch < 4; ch++) begin
            idle();
            if (ch == 0) begin
                period_we = 1'b1; period_in = WIDTH'(10);
                mode_we   = 1'b1; mode_in   = 1'b0;
            end
            duty_we = 1'b1; duty_ch = CH_W'(ch); duty_in = WIDTH'(duties[ch]);
            tick();
        end
        idle();
        guard = 0;
        do begin
            tick();
            guard++;
            n_vec++;
            if ({pwm_out, cnt, period_start, upd_pending} !==
                {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                n_err++;
                $display("FAIL edge_wait: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                         pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
            end
        end while (!m_ps && guard < 600);
        for (int p = 0; p < 3; p++) begin
            hi   = '{0, 0, 0, 0};
            ps_n = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
                ps_n += int'(period_start);
                n_vec++;
                if ({pwm_out, cnt, period_start, upd_pending} !==
                    {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                    n_err++;
                    $display("FAIL edge_cycle: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                             pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (hi[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL edge_high_count ch%0d: got %0d, want %0d", i, hi[i], want[i]);
                end
            end
            n_vec++;
            if (ps_n !== 1) begin
                n_err++;
                $display("FAIL edge_period_start: got %0d pulses, want 1", ps_n);
            end
        end
    endtask

    task automatic test_mid_write();
        int hi, guard;
        for (int k = 0; k < 4; k++) tick();
        n_vec++;
        if (cnt !== WIDTH'(4)) begin
            n_err++;
            $display("FAIL mid_cnt: got %0d, want 4", cnt);
        end
        duty_we = 1'b1; duty_ch = CH_W'(1); duty_in = WIDTH'(7);
        tick();
        idle();
        n_vec++;
        if (upd_pending !== 1'b1) begin
            n_err++;
            $display("FAIL mid_upd_set: got %b, want 1", upd_pending);
        end
        guard = 0;
        do begin
            tick();
            guard++;
            n_vec++;
            if ({pwm_out, cnt, period_start, upd_pending} !==
                {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                n_err++;
                $display("FAIL mid_wait: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                         pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
            end
        end while (!m_ps && guard < 20);
        n_vec++;
        if (upd_pending !== 1'b0) begin
            n_err++;
            $display("FAIL mid_upd_clear: got %b, want 0", upd_pending);
        end
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            hi += int'(pwm_out[1]);
        end
        n_vec++;
        if (hi !== 7) begin
            n_err++;
            $display("FAIL mid_high_count: got %0d, want 7", hi);
        end
    endtask

    task automatic test_center();
        int hi, ps_n, guard, top;
        period_we = 1'b1; period_in = WIDTH'(8);
        mode_we   = 1'b1; mode_in   = 1'b1;
        duty_we   = 1'b1; duty_ch   = CH_W'(1); duty_in = WIDTH'(3);
        tick();
        idle();
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_ps && guard < 30);
        for (int p = 0; p < 2; p++) begin
            hi = 0; ps_n = 0; top = 0;
            for (int k = 0; k < 16; k++) begin
                if (int'(cnt) > top) top = int'(cnt);
                tick();
                hi   += int'(pwm_out[1]);
                ps_n += int'(period_start);
                n_vec++;
                if ({pwm_out, cnt, period_start, upd_pending} !==
                    {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                    n_err++;
                    $display("FAIL center_cycle: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                             pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
                end
            end
            n_vec++;
            if (hi !== 6 || ps_n !== 1 || top !== 7) begin
                n_err++;
                $display("FAIL center_shape: got high=%0d ps=%0d top=%0d, want high=6 ps=1 top=7",
                         hi, ps_n, top);
            end
        end
    endtask

    task automatic test_boundary_write();
        int guard, gap, ps_n, nz;
        guard = 0;
        while (m_phase != m_len() - 1 && guard < 40) begin
            tick();
            guard++;
        end
        period_we = 1'b1; period_in = WIDTH'(1);
        tick();
        idle();
        n_vec++;
        if (period_start !== 1'b1 || upd_pending !== 1'b1) begin
            n_err++;
            $display("FAIL bnd_write_flags: got ps=%b upd=%b, want ps=1 upd=1", period_start, upd_pending);
        end
        gap = 0;
        do begin
            tick();
            gap++;
            n_vec++;
            if ({pwm_out, cnt, period_start, upd_pending} !==
                {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                n_err++;
                $display("FAIL bnd_cycle: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                         pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
            end
        end while (!m_ps && gap < 40);
        n_vec++;
        if (gap !== 16) begin
            n_err++;
            $display("FAIL bnd_delay: got %0d cycles to next period, want 16", gap);
        end
        // Center mode, P=1: two-cycle period, counter stuck at 0.
        ps_n = 0; nz = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ps_n += int'(period_start);
            if (cnt !== '0) nz++;
        end
        n_vec++;
        if (ps_n !== 4 || nz !== 0) begin
            n_err++;
            $display("FAIL p1_center: got ps=%0d nonzero_cnt=%0d, want ps=4 nonzero_cnt=0", ps_n, nz);
        end
        // Edge mode, P=0: period of one cycle.
        period_we = 1'b1; period_in = '0;
        mode_we   = 1'b1; mode_in   = 1'b0;
        tick();
        idle();
        for (int k = 0; k < 3; k++) tick();
        ps_n = 0; nz = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ps_n += int'(period_start);
            if (cnt !== '0) nz++;
        end
        n_vec++;
        if (ps_n !== 8 || nz !== 0 || upd_pending !== 1'b0) begin
            n_err++;
            $display("FAIL p0_edge: got ps=%0d nonzero_cnt=%0d upd=%b, want ps=8 nonzero_cnt=0 upd=0",
                     ps_n, nz, upd_pending);
        end
    endtask

    task automatic test_en_hold();
        int guard, hold_cnt;
        logic [CHANNELS-1:0] hold_pwm;
        period_we = 1'b1; period_in = WIDTH'(10);
        duty_we   = 1'b1; duty_ch   = CH_W'(1); duty_in = WIDTH'(5);
        tick();
        idle();
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_ps && guard < 20);
        for (int k = 0; k < 4; k++) tick();
        en = 1'b0;
        tick();
        hold_cnt = m_cnt();
        hold_pwm = m_pwm;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                duty_we = 1'b1; duty_ch = CH_W'(2); duty_in = WIDTH'(9);
            end
            tick();
            idle();
            n_vec++;
            if (cnt !== WIDTH'(hold_cnt) || pwm_out !== hold_pwm || period_start !== 1'b0 ||
                upd_pending !== m_upd) begin
                n_err++;
                $display("FAIL en_hold: got cnt=%0d pwm=%b ps=%b upd=%b, want cnt=%0d pwm=%b ps=0 upd=%b",
                         cnt, pwm_out, period_start, upd_pending, hold_cnt, hold_pwm, m_upd);
            end
        end
        en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({pwm_out, cnt, period_start, upd_pending} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got pwm=%b cnt=%0d ps=%b upd=%b, want all 0",
                     pwm_out, cnt, period_start, upd_pending);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            en        = ($urandom_range(0, 9) != 0);
            period_we = ($urandom_range(0, 11) == 0);
            period_in = WIDTH'($urandom_range(0, 12));
            duty_we   = ($urandom_range(0, 3) == 0);
            duty_ch   = CH_W'($urandom_range(0, 3));
            duty_in   = WIDTH'($urandom_range(0, 14));
            mode_we   = ($urandom_range(0, 15) == 0);
            mode_in   = $urandom_range(0, 1) != 0;
            tick();
            n_vec++;
            if ({pwm_out, cnt, period_start, upd_pending} !==
                {m_pwm, WIDTH'(m_cnt()), m_ps, m_upd}) begin
                n_err++;
                $display("FAIL random_cycle %0d: got pwm=%b cnt=%0d ps=%b upd=%b, want pwm=%b cnt=%0d ps=%b upd=%b",
                         k, pwm_out, cnt, period_start, upd_pending, m_pwm, m_cnt(), m_ps, m_upd);
            end
        end
        idle();
        en = 1'b1;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        period_in = '0;
        duty_in   = '0;
        duty_ch   = '0;
        mode_in   = 1'b0;
        idle();
        model_reset();

        test_reset();
        test_edge();
        test_mid_write();
        test_center();
        test_boundary_write();
        test_en_hold();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
